// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and data ports,
// data-priority arbitration with a starvation limit for fetch.
module mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    state_t     state;
    logic       owner_d;
    logic       store;
    logic [3:0] cnt;
    logic [3:0] starve_cnt;
    logic       grant_d;

    // fetch only overrides data once it has lost STARVE_LIM grants in a row
    assign grant_d = d_req & ~(if_req & (starve_cnt == LIM));
    assign busy    = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            store      <= 1'b0;
            cnt        <= 4'd0;
            starve_cnt <= 4'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            if_ready   <= 1'b0;
            if_rdata   <= 32'd0;
            d_ready    <= 1'b0;
            d_rdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req | d_req) begin
                        state      <= ACCESS;
                        owner_d    <= grant_d;
                        store      <= grant_d & d_we;
                        mem_en     <= 1'b1;
                        mem_we     <= grant_d & d_we;
                        mem_addr   <= grant_d ? d_addr : if_addr;
                        cnt        <= LAT;
                        starve_cnt <= (grant_d & if_req) ?
                                      ((starve_cnt == LIM) ? LIM : starve_cnt + 4'd1) : 4'd0;
                        if (grant_d)
                            mem_wdata <= d_wdata;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        if (owner_d) begin
                            d_ready <= 1'b1;
                            if (!store)
                                d_rdata <= mem_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (MEM_LAT 1/3/4) on shared stimulus, each
// checked every cycle against a transaction-timing reference model.
module tb_mem_arbiter;
    localparam int N   = 3;
    localparam int LIM = 4;

    function automatic int lat_of(int i);
        return i == 0 ? 1 : (i == 1 ? 3 : 4);
    endfunction

    function automatic logic [31:0] init_word(int k);
        return k == 2 ? 32'h2002_0005 : (32'hA500_0000 | 32'(k));
    endfunction

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;

    logic [N-1:0]       if_ready, d_ready, mem_en, mem_we, busy;
    logic [N-1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [N-1:0][3:0]  starve;

    for (genvar i = 0; i < N; i++) begin : g
        logic [31:0] mem [64];
        logic [4:0]  age;
        logic        ok;
        mem_arbiter #(.MEM_LAT(lat_of(i)), .STARVE_LIM(LIM)) u (
            .clk(clk), .reset(reset),
            .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[i]), .if_ready(if_ready[i]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_rdata(d_rdata[i]), .d_ready(d_ready[i]),
            .mem_en(mem_en[i]), .mem_we(mem_we[i]), .mem_addr(mem_addr[i]),
            .mem_wdata(mem_wdata[i]), .mem_rdata(mem_rdata[i]), .busy(busy[i])
        );
        assign starve[i] = u.starve_cnt;
        // memory drives valid data only in the last cycle of its latency window
        assign ok = (lat_of(i) == 1) ? mem_en[i] : (age == 5'(lat_of(i)));
        assign mem_rdata[i] = ok ? mem[mem_addr[i][7:2]] : (32'hBAD0_0000 | 32'(age));
        initial for (int k = 0; k < 64; k++) mem[k] = init_word(k);
        always @(posedge clk or posedge reset)
            age <= reset ? 5'd0 : mem_en[i] ? 5'd2 : (age != 5'd0 && age < 5'd20) ? 5'(age + 5'd1) : 5'd0;
        always @(posedge clk)
            if (mem_en[i] && mem_we[i]) mem[mem_addr[i][7:2]] <= mem_wdata[i];
    end

    int          tests = 0, fails = 0, cyc = 0;
    logic [31:0] ref_mem [N][64];
    int          g_cyc [N], free_at [N], e_starve [N];
    bit          gv [N], own_d [N], e_we [N], pend [N];
    logic [31:0] e_addr [N], e_wd [N], e_data [N], e_if_rd [N], e_d_rd [N];
    int          en_cnt [N], we_cnt [N], rdy_cnt [N], nseq [N];
    logic [9:0]  seq [N];
    bit          rec = 1'b0;

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[lat%0d] got %h want %h", tag, lat_of(i), obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            gv[i] = 0; free_at[i] = 0; e_starve[i] = 0; pend[i] = 0; own_d[i] = 0; e_we[i] = 0;
            e_addr[i] = 0; e_wd[i] = 0; e_if_rd[i] = 0; e_d_rd[i] = 0; g_cyc[i] = 0;
        end
    endtask

    // decide what each arbiter grants at the end of the current cycle
    task automatic model_pre();
        bit wd;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && cyc == g_cyc[i] + 1) begin
                ref_mem[i][e_addr[i][7:2]] = e_wd[i];
                pend[i] = 0;
            end
            if (cyc >= free_at[i] && (if_req || d_req)) begin
                wd = d_req && !(if_req && e_starve[i] == LIM);
                e_starve[i] = (wd && if_req) ? ((e_starve[i] + 1 > LIM) ? LIM : e_starve[i] + 1) : 0;
                g_cyc[i] = cyc; gv[i] = 1; free_at[i] = cyc + lat_of(i) + 2;
                own_d[i] = wd; e_we[i] = wd && d_we;
                e_addr[i] = wd ? d_addr : if_addr;
                if (wd) e_wd[i] = d_wdata;
                pend[i] = e_we[i];
                e_data[i] = ref_mem[i][e_addr[i][7:2]];
            end
        end
    endtask

    task automatic check_all();
        bit b, en, rd;
        for (int i = 0; i < N; i++) begin
            b  = gv[i] && cyc >= g_cyc[i] + 1 && cyc <= g_cyc[i] + lat_of(i) + 1;
            en = gv[i] && cyc == g_cyc[i] + 1;
            rd = gv[i] && cyc == g_cyc[i] + lat_of(i) + 1;
            if (rd && !e_we[i]) begin
                if (own_d[i]) e_d_rd[i] = e_data[i];
                else          e_if_rd[i] = e_data[i];
            end
            chk("busy",      i, 32'(busy[i]),     32'(b));
            chk("mem_en",    i, 32'(mem_en[i]),   32'(en));
            chk("mem_we",    i, 32'(mem_we[i]),   32'(en && e_we[i]));
            chk("mem_addr",  i, mem_addr[i],      e_addr[i]);
            chk("mem_wdata", i, mem_wdata[i],     e_wd[i]);
            chk("if_ready",  i, 32'(if_ready[i]), 32'(rd && !own_d[i]));
            chk("d_ready",   i, 32'(d_ready[i]),  32'(rd && own_d[i]));
            chk("if_rdata",  i, if_rdata[i],      e_if_rd[i]);
            chk("d_rdata",   i, d_rdata[i],       e_d_rd[i]);
            chk("starve",    i, 32'(starve[i]),   32'(e_starve[i]));
            en_cnt[i]  += int'(mem_en[i]);
            we_cnt[i]  += int'(mem_we[i]);
            rdy_cnt[i] += int'(if_ready[i] | d_ready[i]);
            if (rec && mem_en[i] && nseq[i] < 10) begin
                seq[i] = {seq[i][8:0], mem_addr[i] == if_addr};
                nseq[i]++;
            end
        end
    endtask

    task automatic step();
        model_pre();
        @(posedge clk);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        cyc++;
        #1;
        check_all();
        reset = 1'b0;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < N; i++) begin
            en_cnt[i] = 0; we_cnt[i] = 0; rdy_cnt[i] = 0; nseq[i] = 0; seq[i] = '0;
        end
    endtask

    initial begin
        bit done;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 64; k++) ref_mem[i][k] = init_word(k);
        do_reset();
        clr_counts();
        // single fetch of 0x8
        if_addr = 32'h8; if_req = 1'b1;
        step();
        if_req = 1'b0;
        repeat (8) step();
        for (int i = 0; i < N; i++) begin
            chk("fetch_data", i, if_rdata[i], 32'h2002_0005);
            chk("fetch_rdy",  i, 32'(rdy_cnt[i]), 32'd1);
        end
        // store 7 to 0x54 then load it back
        clr_counts();
        d_addr = 32'h54; d_wdata = 32'd7; d_we = 1'b1; d_req = 1'b1;
        step();
        d_req = 1'b0;
        repeat (8) step();
        for (int i = 0; i < N; i++) begin
            chk("store_we_cycles", i, 32'(we_cnt[i]), 32'd1);
            chk("store_keeps_rdata", i, d_rdata[i], 32'd0);
        end
        d_we = 1'b0; d_req = 1'b1;
        step();
        d_req = 1'b0;
        repeat (8) step();
        for (int i = 0; i < N; i++) chk("load_data", i, d_rdata[i], 32'd7);
        // both held: D,D,D,D,IF,D,D,D,D,IF
        do_reset();
        clr_counts();
        if_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1; rec = 1'b1;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            done = 1;
            for (int i = 0; i < N; i++) if (nseq[i] < 10) done = 0;
        end
        rec = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("order_count", i, 32'(nseq[i]), 32'd10);
            chk("order_seq",   i, 32'(seq[i]),  32'b00_0010_0001);
        end
        // a data grant with fetch idle clears the starvation count
        if_req = 1'b0;
        repeat (14) step();
        for (int i = 0; i < N; i++) chk("starve_clear", i, 32'(starve[i]), 32'd0);
        d_req = 1'b0;
        repeat (8) step();
        // request held through RESP: one access per MEM_LAT+2 cycles
        do_reset();
        clr_counts();
        d_req = 1'b1;
        repeat (30) step();
        for (int i = 0; i < N; i++) chk("throughput", i, 32'(en_cnt[i]), 32'(29 / (lat_of(i) + 2) + 1));
        d_req = 1'b0;
        repeat (8) step();
        // reset in cycle 2 of a load aborts it
        do_reset();
        d_addr = 32'h54; d_we = 1'b0; d_req = 1'b1;
        step();
        d_req = 1'b0;
        step();
        do_reset();
        clr_counts();
        repeat (10) step();
        for (int i = 0; i < N; i++) chk("abort_no_ready", i, 32'(rdy_cnt[i]), 32'd0);
        // random traffic
        repeat (700) begin
            if_req  = 1'($urandom);
            d_req   = 1'($urandom);
            d_we    = 1'($urandom);
            if_addr = {24'($urandom), 3'b0, 3'($urandom_range(0, 7)), 2'($urandom)};
            d_addr  = {24'($urandom), 3'b0, 3'($urandom_range(0, 7)), 2'($urandom)};
            d_wdata = $urandom;
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (10) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
